instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/fetch_pkg.sv | 18 +
 rtl/sync_fifo.sv | 51 +++++
 rtl/instr_fetch_unit.sv | 127 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit and its helpers.
package fetch_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  localparam int DEPTH_DEFAULT   = 4;
  localparam int MAX_OUT_DEFAULT = 2;
  localparam int INSTR_BYTES     = 4;

  // Branch targets may arrive with low address bits set; fetch is word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a flush input; DEPTH need not
// be a power of two. Push and pop in the same cycle are legal at any fill level.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_pop;
  logic             do_push;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches, queues returned
// instructions with their PCs for decode, and discards stale responses after a redirect.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int MAX_OUT = MAX_OUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  output logic        Imem_req_valid,
  output logic [31:0] Imem_req_addr,
  input  logic        Imem_req_ready,
  input  logic        Imem_rsp_valid,
  input  logic [31:0] Imem_rsp_data,
  output logic        Instr_valid,
  output logic [31:0] Instr,
  output logic [31:0] Instr_PC,
  input  logic        Instr_ready
);

  localparam int QW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int RW = QW + 1;
  localparam logic [OW-1:0] MAX_OUT_W = OW'(MAX_OUT);
  localparam logic [RW-1:0] DEPTH_W   = RW'(DEPTH);

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] discard_count;
  logic [OW-1:0] discard_after;
  logic [QW-1:0] q_count;
  logic [63:0]   q_head;
  logic [31:0]   inflight_pc;
  logic [OW-1:0] inflight_count;
  logic [RW-1:0] reserved;
  logic          req_ok;
  logic          accept;
  logic          rsp_fire;
  logic          rsp_keep;
  logic          q_push;
  logic          q_pop;

  // Every request in flight holds a queue slot, so a response can always be stored.
  assign reserved = RW'(q_count) + RW'(outstanding);
  assign req_ok   = (state == RUN) && !Redirect && (outstanding < MAX_OUT_W) &&
                    (reserved < DEPTH_W);

  assign Imem_req_valid = !reset && req_ok;
  assign Imem_req_addr  = fetch_pc;
  assign accept         = Imem_req_valid && Imem_req_ready;

  assign rsp_fire      = !reset && Imem_rsp_valid && (outstanding != '0);
  assign rsp_keep      = rsp_fire && !Redirect && (discard_count == '0);
  assign q_push        = rsp_keep && (inflight_count != '0);
  assign discard_after = outstanding - OW'(rsp_fire);

  assign Instr_valid = !reset && (q_count != '0);
  assign q_pop       = Instr_valid && Instr_ready && !Redirect;
  assign Instr       = Instr_valid ? q_head[31:0]  : '0;
  assign Instr_PC    = Instr_valid ? q_head[63:32] : '0;

  // Fetch control: PC, outstanding count and the post-redirect discard window.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      fetch_pc      <= '0;
      outstanding   <= '0;
      discard_count <= '0;
    end else begin
      if (accept && !rsp_fire) begin
        outstanding <= outstanding + OW'(1);
      end else if (!accept && rsp_fire) begin
        outstanding <= outstanding - OW'(1);
      end

      if (Redirect) begin
        fetch_pc      <= align_word(Redirect_PC);
        discard_count <= discard_after;
        state         <= (discard_after != '0) ? DRAIN : RUN;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
        if (state == DRAIN && rsp_fire) begin
          discard_count <= discard_count - OW'(1);
          if (discard_count == OW'(1)) state <= RUN;
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH(64),
    .DEPTH(DEPTH)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .flush    (Redirect),
    .push     (q_push),
    .push_data({inflight_pc, Imem_rsp_data}),
    .pop      (q_pop),
    .head     (q_head),
    .count    (q_count)
  );

  sync_fifo #(
    .WIDTH(32),
    .DEPTH(MAX_OUT)
  ) u_inflight (
    .clk      (clk),
    .reset    (reset),
    .flush    (Redirect),
    .push     (accept),
    .push_data(fetch_pc),
    .pop      (rsp_keep),
    .head     (inflight_pc),
    .count    (inflight_count)
  );

  // Slot reservation must make queue overflow and counter overrun impossible.
  assert property (@(posedge clk) disable iff (reset)
                   q_push |-> ((q_count != QW'(DEPTH)) || q_pop));
  assert property (@(posedge clk) disable iff (reset) outstanding <= MAX_OUT_W);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: an in-order memory with random latency and a
// transaction-level model of the fetch rules built from plain queues.
module tb_instr_fetch_unit;

  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Redirect = 1'b0;
  logic [31:0] Redirect_PC = '0;
  logic        Imem_req_valid;
  logic [31:0] Imem_req_addr;
  logic        Imem_req_ready = 1'b0;
  logic        Imem_rsp_valid = 1'b0;
  logic [31:0] Imem_rsp_data = '0;
  logic        Instr_valid;
  logic [31:0] Instr;
  logic [31:0] Instr_PC;
  logic        Instr_ready = 1'b0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .DEPTH  (DEPTH),
    .MAX_OUT(MAX_OUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .Redirect      (Redirect),
    .Redirect_PC   (Redirect_PC),
    .Imem_req_valid(Imem_req_valid),
    .Imem_req_addr (Imem_req_addr),
    .Imem_req_ready(Imem_req_ready),
    .Imem_rsp_valid(Imem_rsp_valid),
    .Imem_rsp_data (Imem_rsp_data),
    .Instr_valid   (Instr_valid),
    .Instr         (Instr),
    .Instr_PC      (Instr_PC),
    .Instr_ready   (Instr_ready)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } mem_rsp_t;

  mem_rsp_t    mem_q[$];
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;

  // Model of the fetch rules: PC, queue contents, in-flight PCs, counters.
  logic [31:0] m_pc = '0;
  bit          m_run = 1'b1;
  int          m_out = 0;
  int          m_disc = 0;
  logic [63:0] m_q[$];
  logic [31:0] m_inf[$];

  logic        obs_req_valid, obs_ivalid, exp_req_valid, exp_ivalid;
  logic [31:0] obs_addr, obs_instr, obs_ipc, exp_addr, exp_instr, exp_ipc;
  logic [31:0] acc_addrs[$];
  logic [31:0] del_pcs[$];
  int          n_checks = 0;
  int          n_pass = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic bit rsp_due();
    return (mem_q.size() != 0) && (mem_q[0].due <= cyc);
  endfunction

  // One clock: drive inputs at the falling edge, sample, then advance memory and model.
  task automatic step(input bit rst, input bit redir, input logic [31:0] rpc,
                      input bit rdy, input bit irdy, input bit spur);
    bit          legit, rsp_in, acc_m, rsp_m, pop_m;
    logic [31:0] rdata, ipc;
    int          d;
    @(negedge clk);
    legit  = !rst && rsp_due();
    rdata  = legit ? mem_q[0].data : $urandom;
    rsp_in = legit || (!rst && spur && mem_q.size() == 0);
    reset = rst;
    Redirect = redir;
    Redirect_PC = rpc;
    Imem_req_ready = rdy;
    Instr_ready = irdy;
    Imem_rsp_valid = rsp_in;
    Imem_rsp_data = rdata;
    #1;
    obs_req_valid = Imem_req_valid;
    obs_addr      = Imem_req_addr;
    obs_ivalid    = Instr_valid;
    obs_instr     = Instr;
    obs_ipc       = Instr_PC;
    exp_req_valid = !rst && m_run && !redir && (m_out < MAX_OUT) &&
                    ((m_q.size() + m_out) < DEPTH);
    exp_addr      = m_pc;
    exp_ivalid    = !rst && (m_q.size() != 0);
    exp_ipc       = exp_ivalid ? m_q[0][63:32] : 32'h0;
    exp_instr     = exp_ivalid ? m_q[0][31:0]  : 32'h0;
    if (!rst && obs_req_valid && rdy) acc_addrs.push_back(obs_addr);
    if (!rst && !redir && obs_ivalid && irdy) del_pcs.push_back(obs_ipc);
    @(posedge clk);
    if (rst) begin
      mem_q.delete();
      m_q.delete();
      m_inf.delete();
      m_pc = '0;
      m_run = 1'b1;
      m_out = 0;
      m_disc = 0;
    end else begin
      if (legit) mem_q.delete(0);
      if (obs_req_valid && rdy) begin
        d = cyc + int'($urandom_range(lat_max, lat_min));
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        mem_q.push_back('{due: d, data: mem_word(obs_addr)});
      end
      acc_m = exp_req_valid && rdy;
      rsp_m = rsp_in && (m_out != 0);
      pop_m = exp_ivalid && irdy;
      if (redir) begin
        m_q.delete();
        m_inf.delete();
        m_pc   = rpc & 32'hFFFF_FFFC;
        m_out  = m_out - int'(rsp_m);
        m_disc = m_out;
        m_run  = (m_disc == 0);
      end else begin
        if (pop_m) m_q.delete(0);
        if (rsp_m) begin
          if (m_run) begin
            if (m_inf.size() != 0) begin
              ipc = m_inf.pop_front();
              m_q.push_back({ipc, rdata});
            end
          end else begin
            m_disc--;
            if (m_disc == 0) m_run = 1'b1;
          end
          m_out--;
        end
        if (acc_m) begin
          m_inf.push_back(m_pc);
          m_pc = m_pc + 32'd4;
          m_out++;
        end
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    acc_addrs.delete();
    del_pcs.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (obs_req_valid !== 1'b0 || obs_ivalid !== 1'b0)
      $display("[TB] FAIL reset_valids: got req=%b instr=%b expected 0/0", obs_req_valid, obs_ivalid);
    else n_pass++;
    n_checks++;
    if (obs_instr !== 32'h0 || obs_ipc !== 32'h0)
      $display("[TB] FAIL reset_instr: got %h/%h expected 0/0", obs_instr, obs_ipc);
    else n_pass++;
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (obs_req_valid !== 1'b1 || obs_addr !== 32'h0)
      $display("[TB] FAIL reset_first_req: got valid=%b addr=%h expected 1/00000000", obs_req_valid, obs_addr);
    else n_pass++;
  endtask

  task automatic test_sequential();
    logic [31:0] want;
    do_reset();
    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (obs_req_valid !== exp_req_valid)
        $display("[TB] FAIL seq_req_valid c%0d: got %b expected %b", cyc, obs_req_valid, exp_req_valid);
      else n_pass++;
      if (obs_ivalid) begin
        n_checks++;
        if (obs_instr !== mem_word(obs_ipc))
          $display("[TB] FAIL seq_instr_data: got %h expected %h", obs_instr, mem_word(obs_ipc));
        else n_pass++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      want = 32'(i * 4);
      n_checks++;
      if (acc_addrs.size() <= i || acc_addrs[i] !== want)
        $display("[TB] FAIL seq_req_addr%0d: got %h expected %h", i,
                 (acc_addrs.size() > i) ? acc_addrs[i] : 32'hDEAD_BEEF, want);
      else n_pass++;
      n_checks++;
      if (del_pcs.size() <= i || del_pcs[i] !== want)
        $display("[TB] FAIL seq_instr_pc%0d: got %h expected %h", i,
                 (del_pcs.size() > i) ? del_pcs[i] : 32'hDEAD_BEEF, want);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obs_req_valid !== 1'b0 || obs_ivalid !== 1'b1 || acc_addrs.size() != 4)
      $display("[TB] FAIL bp_full: got req=%b instr=%b reqs=%0d expected 0/1/4",
               obs_req_valid, obs_ivalid, acc_addrs.size());
    else n_pass++;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (del_pcs.size() <= i || del_pcs[i] !== 32'(i * 4))
        $display("[TB] FAIL bp_order%0d: got %h expected %h", i,
                 (del_pcs.size() > i) ? del_pcs[i] : 32'hDEAD_BEEF, 32'(i * 4));
      else n_pass++;
    end
    n_checks++;
    if (acc_addrs.size() < 5 || acc_addrs[4] !== 32'h10)
      $display("[TB] FAIL bp_resume: got %h expected 00000010",
               (acc_addrs.size() > 4) ? acc_addrs[4] : 32'hDEAD_BEEF);
    else n_pass++;
  endtask

  task automatic test_redirect_drain();
    bit found = 1'b0;
    do_reset();
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m_out == MAX_OUT) found = 1'b1;
      else step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    n_checks++;
    if (!found) $display("[TB] FAIL drain_setup: got outstanding=%0d expected %0d", m_out, MAX_OUT);
    else n_pass++;
    step(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (obs_req_valid !== 1'b0 || obs_ivalid !== 1'b0)
        $display("[TB] FAIL drain_quiet%0d: got req=%b instr=%b expected 0/0", i, obs_req_valid, obs_ivalid);
      else n_pass++;
    end
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (obs_req_valid !== 1'b1 || obs_addr !== 32'h100)
      $display("[TB] FAIL drain_next_req: got valid=%b addr=%h expected 1/00000100", obs_req_valid, obs_addr);
    else n_pass++;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (del_pcs.size() == 0 || del_pcs[0] !== 32'h100)
      $display("[TB] FAIL drain_first_pc: got %h expected 00000100",
               (del_pcs.size() > 0) ? del_pcs[0] : 32'hDEAD_BEEF);
    else n_pass++;
  endtask

  task automatic test_redirect_coincident();
    bit found = 1'b0;
    do_reset();
    lat_min = 2;
    lat_max = 2;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_q.size() >= 1 && rsp_due() && m_out == MAX_OUT) found = 1'b1;
      else step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    n_checks++;
    if (!found) $display("[TB] FAIL coin_setup: got queue=%0d outstanding=%0d expected >=1/%0d",
                         m_q.size(), m_out, MAX_OUT);
    else n_pass++;
    step(1'b0, 1'b1, 32'h203, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (obs_req_valid !== 1'b0 || obs_ivalid !== 1'b0)
      $display("[TB] FAIL coin_drain: got req=%b instr=%b expected 0/0", obs_req_valid, obs_ivalid);
    else n_pass++;
    lat_min = 1;
    lat_max = 1;
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (obs_req_valid !== 1'b1 || obs_addr !== 32'h200)
      $display("[TB] FAIL coin_next_req: got valid=%b addr=%h expected 1/00000200", obs_req_valid, obs_addr);
    else n_pass++;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (del_pcs.size() == 0 || del_pcs[0] !== 32'h200)
      $display("[TB] FAIL coin_first_pc: got %h expected 00000200",
               (del_pcs.size() > 0) ? del_pcs[0] : 32'hDEAD_BEEF);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] want[3];
    want[0] = 32'hFFFF_FFF8;
    want[1] = 32'hFFFF_FFFC;
    want[2] = 32'h0000_0000;
    do_reset();
    lat_min = 1;
    lat_max = 1;
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (acc_addrs.size() <= i || acc_addrs[i] !== want[i])
        $display("[TB] FAIL wrap_req%0d: got %h expected %h", i,
                 (acc_addrs.size() > i) ? acc_addrs[i] : 32'hDEAD_BEEF, want[i]);
      else n_pass++;
    end
    n_checks++;
    if (del_pcs.size() < 3 || del_pcs[0] !== want[0] || del_pcs[2] !== want[2])
      $display("[TB] FAIL wrap_instr_pc: got %0d entries first %h expected %h", del_pcs.size(),
               (del_pcs.size() > 0) ? del_pcs[0] : 32'hDEAD_BEEF, want[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    do_reset();
    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_q.size() == 3) found = 1'b1;
      else step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    n_checks++;
    if (!found || obs_ivalid !== 1'b1)
      $display("[TB] FAIL rstmid_setup: got queue=%0d instr_valid=%b expected 3/1", m_q.size(), obs_ivalid);
    else n_pass++;
    step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obs_ivalid !== 1'b0)
      $display("[TB] FAIL rstmid_instr_valid: got %b expected 0", obs_ivalid);
    else n_pass++;
    n_checks++;
    if (obs_req_valid !== 1'b1 || obs_addr !== 32'h0)
      $display("[TB] FAIL rstmid_first_req: got valid=%b addr=%h expected 1/00000000", obs_req_valid, obs_addr);
    else n_pass++;
  endtask

  task automatic test_random();
    bit          rdy, irdy, redir, spur;
    logic [31:0] rpc;
    do_reset();
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      rdy   = ($urandom_range(3, 0) != 0);
      irdy  = ($urandom_range(9, 0) < 7);
      redir = ($urandom_range(24, 0) == 0);
      spur  = ($urandom_range(9, 0) == 0);
      rpc   = $urandom;
      step(1'b0, redir, rpc, rdy, irdy, spur);
      n_checks++;
      if (obs_req_valid !== exp_req_valid)
        $display("[TB] FAIL rnd_req_valid c%0d: got %b expected %b", cyc, obs_req_valid, exp_req_valid);
      else n_pass++;
      if (exp_req_valid) begin
        n_checks++;
        if (obs_addr !== exp_addr)
          $display("[TB] FAIL rnd_req_addr c%0d: got %h expected %h", cyc, obs_addr, exp_addr);
        else n_pass++;
      end
      n_checks++;
      if (obs_ivalid !== exp_ivalid)
        $display("[TB] FAIL rnd_instr_valid c%0d: got %b expected %b", cyc, obs_ivalid, exp_ivalid);
      else n_pass++;
      if (exp_ivalid) begin
        n_checks++;
        if (obs_ipc !== exp_ipc || obs_instr !== exp_instr)
          $display("[TB] FAIL rnd_head c%0d: got %h/%h expected %h/%h", cyc,
                   obs_ipc, obs_instr, exp_ipc, exp_instr);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_drain();
    test_redirect_coincident();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
